// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit pin between NUM_REQ byte-stream requesters.
// Requesters are picked round-robin one byte at a time; a requester whose
// byte is not flagged last keeps the line locked until its packet ends.
// The granted byte goes out as 8N1: one start bit, eight data bits LSB
// first, one stop bit, each CLKS_PER_BIT core clocks long.

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_REQ-1:0]                                 req_valid,
    input  logic [8*NUM_REQ-1:0]                               req_data,
    input  logic [NUM_REQ-1:0]                                 req_last,
    output logic [NUM_REQ-1:0]                                 req_ready,
    output logic                                               uart_tx,
    output logic                                               busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]   grant_id
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Registered state
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_busy;
    logic [ID_W-1:0]   r_grant;
    logic [ID_W-1:0]   r_last_grant;
    logic              r_locked;

    // Next-state values
    state_t            w_state_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [2:0]        w_bit_idx_nx;
    logic [7:0]        w_shift_nx;
    logic              w_tx_nx;
    logic [ID_W-1:0]   w_grant_nx;
    logic [ID_W-1:0]   w_last_grant_nx;
    logic              w_locked_nx;

    // Arbitration results
    logic              w_found;
    logic [ID_W-1:0]   w_sel;
    logic [7:0]        w_byte;
    logic              w_last;
    logic              w_accept;
    logic              w_bit_end;

    // The current bit period ends on the last count of the baud counter.
    assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Pick the requester to serve: the lock owner only while locked,
    // otherwise the first valid one after the previous grant.
    always_comb begin
        logic [ID_W:0] v_idx;
        logic          v_hit;
        w_found = 1'b0;
        w_sel   = '0;
        v_idx   = '0;
        v_hit   = 1'b0;
        if (r_locked) begin
            // The lock owner is always the previous grant.
            w_sel = r_last_grant;
            for (int j = 0; j < NUM_REQ; j++) begin
                w_found = w_found | (req_valid[j] & (r_last_grant == ID_W'(j)));
            end
        end else begin
            // Walk the ring starting one past the previous grant; the
            // previous grant itself is visited last.
            for (int i = 1; i <= NUM_REQ; i++) begin
                v_idx = {1'b0, r_last_grant} + (ID_W+1)'(i);
                v_idx = (v_idx >= (ID_W+1)'(NUM_REQ)) ? (v_idx - (ID_W+1)'(NUM_REQ)) : v_idx;
                for (int j = 0; j < NUM_REQ; j++) begin
                    v_hit   = !w_found && req_valid[j] && (v_idx == (ID_W+1)'(j));
                    w_sel   = v_hit ? ID_W'(j) : w_sel;
                    w_found = w_found | v_hit;
                end
            end
        end
    end

    // Route the selected requester's byte and end-of-packet flag.
    always_comb begin
        w_byte = 8'h00;
        w_last = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_byte = (w_sel == ID_W'(j)) ? req_data[8*j +: 8] : w_byte;
            w_last = (w_sel == ID_W'(j)) ? req_last[j] : w_last;
        end
    end

    // A byte is taken only while idle and never during reset.
    assign w_accept = (r_state == ST_IDLE) && w_found && !rst;

    // One-hot ready toward the selected requester in the accepting cycle.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = w_accept && (w_sel == ID_W'(j));
        end
    end

    // Frame sequencer: next state, baud counter, shifter and line level.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt + CNT_W'(1);
        w_bit_idx_nx    = r_bit_idx;
        w_shift_nx      = r_shift;
        w_tx_nx         = r_tx;
        w_grant_nx      = r_grant;
        w_last_grant_nx = r_last_grant;
        w_locked_nx     = r_locked;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (w_accept) begin
                    w_state_nx      = ST_START;
                    w_shift_nx      = w_byte;
                    w_bit_idx_nx    = 3'd0;
                    w_tx_nx         = 1'b0;
                    w_grant_nx      = w_sel;
                    w_last_grant_nx = w_sel;
                    w_locked_nx     = !w_last;
                end else begin
                    w_tx_nx = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nx   = ST_DATA;
                    w_cnt_nx     = '0;
                    w_bit_idx_nx = 3'd0;
                    w_tx_nx      = r_shift[0];
                end else begin
                    w_tx_nx = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nx = ST_STOP;
                        w_tx_nx    = 1'b1;
                    end else begin
                        // r_shift[0] is always the bit on the wire.
                        w_bit_idx_nx = r_bit_idx + 3'd1;
                        w_tx_nx      = r_shift[1];
                        w_shift_nx   = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_tx_nx = r_shift[0];
                end
            end
            ST_STOP: begin
                w_tx_nx = 1'b1;
                if (w_bit_end) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_state_nx = ST_STOP;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_tx_nx    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'h00;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_bit_idx    <= w_bit_idx_nx;
            r_shift      <= w_shift_nx;
            r_tx         <= w_tx_nx;
            r_busy       <= (w_state_nx != ST_IDLE);
            r_grant      <= w_grant_nx;
            r_last_grant <= w_last_grant_nx;
            r_locked     <= w_locked_nx;
        end
    end

    assign uart_tx  = r_tx;
    assign busy     = r_busy;
    assign grant_id = r_grant;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single board UART transmit line between `NUM_REQ` byte-stream requesters (e.g. the SoC console and a hardware debug/status streamer) and serialises the granted byte as 8N1. Round-robin arbitration runs at byte granularity. Optional packet locking keeps a multi-byte message from one requester contiguous on the wire. The block sits between the requesters and the `uart_tx` pin, in the core clock domain.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `CLKS_PER_BIT`, 434: core clocks per UART bit (50 MHz / 115200); minimum 2.
- `clk`  in  1: core clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: requester i has a byte to send.
- `req_data`  in  8*NUM_REQ: byte of requester i at bits [8i+7:8i]; must hold while valid.
- `req_last`  in  NUM_REQ: byte of requester i ends its packet (releases lock).
- `req_ready`  out  NUM_REQ: one-hot; byte of requester i accepted this cycle when valid&ready.
- `uart_tx`  out  1: serial output, idle high, registered.
- `busy`  out  1: frame in progress (any state other than IDLE).
- `grant_id`  out  max(1,clog2(NUM_REQ)): index of the requester whose byte is on the wire or was last sent.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE
  - When unlocked, selects the first requester with `req_valid`=1, searching round-robin from `(last_grant+1) mod NUM_REQ`.
  - When locked, only the lock owner is eligible. Other requesters wait even if valid.
  - `req_ready[sel]`=1 combinationally in IDLE when a requester is selected; all other ready bits are 0.
  - On accept: latch the data into the shift register; set `grant_id`=`last_grant`=sel; lock to sel if `req_last`=0, clear the lock if `req_last`=1; go to START.
- START: `uart_tx`=0 for `CLKS_PER_BIT` clocks, then go to DATA.
- DATA: 8 bits LSB first, each `CLKS_PER_BIT` clocks; a 3-bit index counts 0..7, then go to STOP.
- STOP: `uart_tx`=1 for `CLKS_PER_BIT` clocks, then go to IDLE.
- Baud counter
  - Width `clog2(CLKS_PER_BIT)`.
  - Reloads to 0 on every state or bit change.
  - A bit ends when the counter reaches `CLKS_PER_BIT-1`.
- `req_ready` is 0 in START/DATA/STOP; `req_valid` is ignored there.
- Lock owner drops `req_valid` mid-packet: the arbiter waits indefinitely in IDLE with `uart_tx`=1. There is no timeout.
- Simultaneous valids: exactly one is accepted per frame; round-robin guarantees each waiting unlocked requester a slot within `NUM_REQ` frames.
- `req_valid` rising in the same cycle the FSM enters IDLE: arbitration happens the following cycle (IDLE lasts at least 1 cycle).

## Timing
- Reset values
  - `uart_tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0.
  - State IDLE, lock cleared.
  - `last_grant`=NUM_REQ-1, so requester 0 has first priority.
- `rst` asserted mid-frame: on the next edge all registers take their reset values and `uart_tx` returns high immediately. The partial frame is abandoned, not retried.
- Accept at edge T: `busy`=1 and `uart_tx`=0 from T+1.
  - Start bit occupies cycles T+1..T+CLKS_PER_BIT.
  - Data bit k starts at T+1+(k+1)·CLKS_PER_BIT.
  - Stop bit ends at T+10·CLKS_PER_BIT.
  - `busy`=0 from T+1+10·CLKS_PER_BIT.
- Back-to-back throughput: one byte per `10·CLKS_PER_BIT+1` clocks; the earliest next accept is the first IDLE cycle.
- `grant_id` is valid from T+1 and holds until the next accept.

## Test plan
(`CLKS_PER_BIT`=4, `NUM_REQ`=2 unless stated.)
- Single byte: requester 0 sends 0xA5 with last=1 → `req_ready[0]` high 1 cycle; `uart_tx` shows 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `busy` high exactly 40 cycles; `grant_id`=0.
- Round-robin: both requesters valid continuously with last=1, data 0x11/0x22 → wire order 0x11,0x22,0x11,0x22; frames 41 cycles apart.
- Packet lock: requester 1 sends 0x01(last=0), 0x02(last=0), 0x03(last=1) while requester 0 is valid with 0x55 → wire order 0x01,0x02,0x03,0x55.
- Lock stall: requester 0 sends 0x10(last=0) then drops valid for 100 cycles while requester 1 is valid → `uart_tx` stays 1 and `req_ready[1]` stays 0 until requester 0 sends 0x20(last=1); then 0x20 is sent, then requester 1's byte.
- Reset mid-frame: assert `rst` during data bit 3 → next cycle `uart_tx`=1, `busy`=0, lock cleared; after release, requester 0 wins over a simultaneous requester 1.
- `NUM_REQ`=4, `CLKS_PER_BIT`=2: requesters 1 and 3 valid, `last_grant`=1 → requester 3 is granted before requester 1.
